// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared forward codes, FSM encoding and defaults for the hazard/forward unit
//
// Purpose: constants shared by hazard_forward_unit and fwd_select.
//   fwd_code_e : operand forward select driven onto fwd_ex.
//   ST_IDLE / ST_STALL : load-use interlock state encoding.
//   REG_W_DEF : default register address width.
// Ports: none (package).
package pipeline_pkg;

  localparam int REG_W_DEF = 3;

  typedef enum logic [1:0] {
    NOF = 2'b00,  // register file
    MEF = 2'b01,  // ME result
    WBF = 2'b10,  // WB result
    HLF = 2'b11   // WB hold register (value WB wrote one cycle earlier)
  } fwd_code_e;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-operand youngest-first forward select comparator
//
// Purpose: decides, for one ID source operand, which pipeline stage will hold
// the newest copy of the register once the instruction reaches EX.
// Ports:
//   src, used               : ID source address and "reads register" flag.
//   ex_valid/ex_rdst        : EX writer.
//   me_valid/me_rdst        : ME writer.
//   wb_valid/wb_rdst        : WB writer.
//   sel                     : forward code for this operand.
//   ex_hit                  : operand matches the EX writer (feeds load-use detect).
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int ZERO_REG_EN = 0
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rdst,
  input  logic             me_valid,
  input  logic [REG_W-1:0] me_rdst,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rdst,
  output logic [1:0]       sel,
  output logic             ex_hit
);

  logic src_ok;
  logic me_hit;
  logic wb_hit;

  // Register 0 is hardwired when ZERO_REG_EN is set, so it never needs a bypass.
  assign src_ok = used && !((ZERO_REG_EN != 0) && (src == '0));

  always_comb begin
    ex_hit = src_ok && ex_valid && (src == ex_rdst);
    me_hit = src_ok && me_valid && (src == me_rdst);
    wb_hit = src_ok && wb_valid && (src == wb_rdst);
    // Codes are shifted one stage: they are used a cycle later, when the
    // producer seen now in EX has moved to ME, and so on.
    if (ex_hit) begin
      sel = MEF;
    end else if (me_hit) begin
      sel = WBF;
    end else if (wb_hit) begin
      sel = HLF;
    end else begin
      sel = NOF;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - registered operand forwarding with load-use interlock
//
// Purpose: computes forward selects in ID and registers them into EX, inserts
// LOAD_STALL bubbles on load-use, and honours freeze (ext_stall) and flush.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset.
//   id_valid, id_src,
//   id_src_used              : ID instruction and its source operands.
//   ex_valid, ex_is_load,
//   ex_rdst                  : EX writer and whether it is a load.
//   me_valid, me_rdst        : ME writer.
//   wb_valid, wb_rdst        : WB writer.
//   ext_stall                : freeze from other sources.
//   flush                    : kill ID/EX contents.
//   stall                    : combinational hold for PC and IF/ID.
//   ex_bubble                : registered, EX holds a bubble.
//   fwd_ex                   : registered per-operand forward selects for EX.
module hazard_forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int NUM_SRC     = 2,
  parameter int LOAD_STALL  = 1,
  parameter int ZERO_REG_EN = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     ex_valid,
  input  logic                     ex_is_load,
  input  logic [REG_W-1:0]         ex_rdst,
  input  logic                     me_valid,
  input  logic [REG_W-1:0]         me_rdst,
  input  logic                     wb_valid,
  input  logic [REG_W-1:0]         wb_rdst,
  input  logic                     ext_stall,
  input  logic                     flush,
  output logic                     stall,
  output logic                     ex_bubble,
  output logic [2*NUM_SRC-1:0]     fwd_ex
);

  // Extra STALL cycles after the detect cycle; unused when LOAD_STALL is 1.
  localparam logic [1:0] CNT_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

  logic [2*NUM_SRC-1:0] fwd_calc;
  logic [NUM_SRC-1:0]   ex_hit;
  logic                 detect;

  logic [0:0]           state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 ex_bubble_q, ex_bubble_d;
  logic [2*NUM_SRC-1:0] fwd_ex_q, fwd_ex_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sel
    fwd_select #(
      .REG_W       (REG_W),
      .ZERO_REG_EN (ZERO_REG_EN)
    ) u_fwd_select (
      .src      (id_src[i*REG_W +: REG_W]),
      .used     (id_src_used[i]),
      .ex_valid (ex_valid),
      .ex_rdst  (ex_rdst),
      .me_valid (me_valid),
      .me_rdst  (me_rdst),
      .wb_valid (wb_valid),
      .wb_rdst  (wb_rdst),
      .sel      (fwd_calc[2*i +: 2]),
      .ex_hit   (ex_hit[i])
    );
  end

  // Detect is only looked at in IDLE; the STALL countdown owns the remaining bubbles.
  assign detect = (state_q == ST_IDLE) && id_valid && ex_valid && ex_is_load && (|ex_hit);

  // Gated by rst so the hold request is quiet while the pipeline is in reset.
  assign stall = (detect || (state_q == ST_STALL)) && !flush && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ex_bubble_d = ex_bubble_q;
    fwd_ex_d    = fwd_ex_q;

    if (flush) begin
      ex_bubble_d = 1'b1;
      fwd_ex_d    = '0;
      state_d     = ST_IDLE;
      cnt_d       = 2'd0;
    end else if (!ext_stall) begin
      if (stall || !id_valid) begin
        ex_bubble_d = 1'b1;
        fwd_ex_d    = '0;
      end else begin
        ex_bubble_d = 1'b0;
        fwd_ex_d    = fwd_calc;
      end

      if (state_q == ST_IDLE) begin
        // With a single bubble the load simply moves to ME and detect clears.
        if (detect && (LOAD_STALL > 1)) begin
          state_d = ST_STALL;
          cnt_d   = CNT_INIT;
        end
      end else begin
        if (cnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      ex_bubble_q <= 1'b1;
      fwd_ex_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_bubble_q <= ex_bubble_d;
      fwd_ex_q    <= fwd_ex_d;
    end
  end

  assign ex_bubble = ex_bubble_q;
  assign fwd_ex    = fwd_ex_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [5:0] id_src;
  logic [1:0] id_src_used;
  logic       ex_valid, ex_is_load;
  logic [2:0] ex_rdst;
  logic       me_valid;
  logic [2:0] me_rdst;
  logic       wb_valid;
  logic [2:0] wb_rdst;
  logic       ext_stall, flush;

  logic       stall1, bub1, stall2, bub2, stall3, bub3, stallz, bubz;
  logic [3:0] fwd1, fwd2, fwd3, fwdz;

  int errors = 0;
  int checks = 0;

  hazard_forward_unit #(.REG_W(3), .NUM_SRC(2), .LOAD_STALL(1), .ZERO_REG_EN(0)) u_ls1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rdst(ex_rdst),
    .me_valid(me_valid), .me_rdst(me_rdst), .wb_valid(wb_valid), .wb_rdst(wb_rdst),
    .ext_stall(ext_stall), .flush(flush), .stall(stall1), .ex_bubble(bub1), .fwd_ex(fwd1));

  hazard_forward_unit #(.REG_W(3), .NUM_SRC(2), .LOAD_STALL(2), .ZERO_REG_EN(0)) u_ls2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rdst(ex_rdst),
    .me_valid(me_valid), .me_rdst(me_rdst), .wb_valid(wb_valid), .wb_rdst(wb_rdst),
    .ext_stall(ext_stall), .flush(flush), .stall(stall2), .ex_bubble(bub2), .fwd_ex(fwd2));

  hazard_forward_unit #(.REG_W(3), .NUM_SRC(2), .LOAD_STALL(3), .ZERO_REG_EN(0)) u_ls3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rdst(ex_rdst),
    .me_valid(me_valid), .me_rdst(me_rdst), .wb_valid(wb_valid), .wb_rdst(wb_rdst),
    .ext_stall(ext_stall), .flush(flush), .stall(stall3), .ex_bubble(bub3), .fwd_ex(fwd3));

  hazard_forward_unit #(.REG_W(3), .NUM_SRC(2), .LOAD_STALL(1), .ZERO_REG_EN(1)) u_z (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rdst(ex_rdst),
    .me_valid(me_valid), .me_rdst(me_rdst), .wb_valid(wb_valid), .wb_rdst(wb_rdst),
    .ext_stall(ext_stall), .flush(flush), .stall(stallz), .ex_bubble(bubz), .fwd_ex(fwdz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       idv;
    logic [2:0] s0, s1;
    logic [1:0] used;
    logic       exv, exl;
    logic [2:0] exr;
    logic       mev;
    logic [2:0] mer;
    logic       wbv;
    logic [2:0] wbr;
    logic       e_stall, e_bub;
    logic [3:0] e_fwd;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic idv, logic [2:0] s0, logic [2:0] s1, logic [1:0] used,
                              logic exv, logic exl, logic [2:0] exr, logic mev, logic [2:0] mer,
                              logic wbv, logic [2:0] wbr, logic e_stall, logic e_bub,
                              logic [3:0] e_fwd);
    vec_t v;
    v.idv = idv; v.s0 = s0; v.s1 = s1; v.used = used;
    v.exv = exv; v.exl = exl; v.exr = exr; v.mev = mev; v.mer = mer;
    v.wbv = wbv; v.wbr = wbr; v.e_stall = e_stall; v.e_bub = e_bub; v.e_fwd = e_fwd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_src = '0; id_src_used = '0;
    ex_valid = 0; ex_is_load = 0; ex_rdst = '0;
    me_valid = 0; me_rdst = '0; wb_valid = 0; wb_rdst = '0;
    ext_stall = 0; flush = 0;
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.idv; id_src = {v.s1, v.s0}; id_src_used = v.used;
    ex_valid = v.exv; ex_is_load = v.exl; ex_rdst = v.exr;
    me_valid = v.mev; me_rdst = v.mer; wb_valid = v.wbv; wb_rdst = v.wbr;
  endtask

  task automatic reset_all();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Load in EX writing r2, ID operand 1 reads r2.
  task automatic load_use_inputs();
    id_valid = 1; id_src = {3'd2, 3'd0}; id_src_used = 2'b10;
    ex_valid = 1; ex_is_load = 1; ex_rdst = 3'd2;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    // idv s0 s1 used exv exl exr mev mer wbv wbr | stall bub fwd
    tbl[0]  = mk(1, 5, 0, 2'b01, 1, 0, 5, 1, 5, 1, 5, 0, 0, 4'b0001);
    tbl[1]  = mk(1, 5, 0, 2'b01, 0, 0, 5, 1, 5, 1, 5, 0, 0, 4'b0010);
    tbl[2]  = mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 1, 5, 0, 0, 4'b0011);
    tbl[3]  = mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    tbl[4]  = mk(1, 5, 5, 2'b01, 1, 0, 5, 1, 5, 1, 5, 0, 0, 4'b0001);
    tbl[5]  = mk(1, 3, 5, 2'b01, 1, 0, 5, 1, 5, 1, 5, 0, 0, 4'b0000);
    tbl[6]  = mk(0, 5, 0, 2'b01, 1, 0, 5, 1, 5, 1, 5, 0, 1, 4'b0000);
    tbl[7]  = mk(1, 1, 2, 2'b11, 1, 0, 1, 1, 2, 0, 0, 0, 0, 4'b1001);
    tbl[8]  = mk(1, 4, 4, 2'b11, 0, 0, 0, 1, 4, 1, 4, 0, 0, 4'b1010);
    tbl[9]  = mk(1, 0, 2, 2'b10, 1, 1, 2, 0, 0, 0, 0, 1, 1, 4'b0000);
    tbl[10] = mk(1, 3, 6, 2'b10, 1, 1, 3, 0, 0, 1, 6, 0, 0, 4'b1100);
    tbl[11] = mk(1, 7, 0, 2'b01, 0, 1, 7, 0, 0, 1, 7, 0, 0, 4'b0011);
    tbl[12] = mk(1, 2, 2, 2'b11, 0, 0, 0, 1, 3, 1, 3, 0, 0, 4'b0000);

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bubble", 32'(bub1), 32'd1);
    chk("reset_fwd", 32'(fwd1), 32'd0);
    chk("reset_stall", 32'(stall1), 32'd0);
    rst = 0;

    // Asynchronous reset clears a live select without a clock edge.
    drive(tbl[0]);
    edge1();
    chk("pre_async_fwd", 32'(fwd1), 32'h1);
    #2 rst = 1;
    #1;
    chk("async_rst_fwd", 32'(fwd1), 32'd0);
    chk("async_rst_bubble", 32'(bub1), 32'd1);
    edge1();
    rst = 0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("vec%0d_stall", i), 32'(stall1), 32'(tbl[i].e_stall));
      edge1();
      chk($sformatf("vec%0d_bubble", i), 32'(bub1), 32'(tbl[i].e_bub));
      chk($sformatf("vec%0d_fwd", i), 32'(fwd1), 32'(tbl[i].e_fwd));
    end

    // LOAD_STALL=1: one bubble, then the load is in ME -> WBF.
    reset_all();
    load_use_inputs();
    #2 chk("ls1_detect_stall", 32'(stall1), 32'd1);
    edge1();
    chk("ls1_bubble", 32'(bub1), 32'd1);
    ex_valid = 0; ex_is_load = 0; me_valid = 1; me_rdst = 3'd2;
    #2 chk("ls1_release_stall", 32'(stall1), 32'd0);
    edge1();
    chk("ls1_release_bubble", 32'(bub1), 32'd0);
    chk("ls1_release_fwd", 32'(fwd1), 32'b1000);

    // LOAD_STALL=2 with a freeze on the second bubble cycle.
    reset_all();
    load_use_inputs();
    #2 chk("ls2_c1_stall", 32'(stall2), 32'd1);
    edge1();
    chk("ls2_c1_bubble", 32'(bub2), 32'd1);
    ex_valid = 0; ex_is_load = 0; me_valid = 1; me_rdst = 3'd2; ext_stall = 1;
    #2 chk("ls2_c2_frozen_stall", 32'(stall2), 32'd1);
    edge1();
    chk("ls2_c2_bubble", 32'(bub2), 32'd1);
    ext_stall = 0;
    #2 chk("ls2_c3_stall", 32'(stall2), 32'd1);
    edge1();
    me_valid = 0; wb_valid = 1; wb_rdst = 3'd2;
    #2 chk("ls2_release_stall", 32'(stall2), 32'd0);
    edge1();
    chk("ls2_release_bubble", 32'(bub2), 32'd0);
    chk("ls2_release_fwd", 32'(fwd2), 32'b1100);

    // LOAD_STALL=3: three stall cycles, then register file.
    reset_all();
    load_use_inputs();
    #2 chk("ls3_c1_stall", 32'(stall3), 32'd1);
    edge1();
    ex_valid = 0; ex_is_load = 0; me_valid = 1; me_rdst = 3'd2;
    #2 chk("ls3_c2_stall", 32'(stall3), 32'd1);
    edge1();
    me_valid = 0; wb_valid = 1; wb_rdst = 3'd2;
    #2 chk("ls3_c3_stall", 32'(stall3), 32'd1);
    edge1();
    wb_valid = 0;
    #2 chk("ls3_release_stall", 32'(stall3), 32'd0);
    edge1();
    chk("ls3_release_bubble", 32'(bub3), 32'd0);
    chk("ls3_release_fwd", 32'(fwd3), 32'd0);

    // Flush while in STALL (LOAD_STALL=3).
    reset_all();
    load_use_inputs();
    edge1();
    ex_valid = 0; ex_is_load = 0; me_valid = 1; me_rdst = 3'd2; flush = 1;
    #2 chk("flush_stall", 32'(stall3), 32'd0);
    edge1();
    chk("flush_bubble", 32'(bub3), 32'd1);
    chk("flush_fwd", 32'(fwd3), 32'd0);
    flush = 0; me_valid = 0;
    id_src = {3'd0, 3'd5}; id_src_used = 2'b01; wb_valid = 1; wb_rdst = 3'd5;
    #2 chk("post_flush_idle_stall", 32'(stall3), 32'd0);
    edge1();
    chk("post_flush_fwd", 32'(fwd3), 32'b0011);
    chk("post_flush_bubble", 32'(bub3), 32'd0);

    // Register 0 load-use with and without ZERO_REG_EN.
    reset_all();
    id_valid = 1; id_src = '0; id_src_used = 2'b01;
    ex_valid = 1; ex_is_load = 1; ex_rdst = 3'd0;
    #2;
    chk("zero_en_stall", 32'(stallz), 32'd0);
    chk("zero_dis_stall", 32'(stall1), 32'd1);
    edge1();
    chk("zero_en_fwd", 32'(fwdz), 32'd0);
    chk("zero_en_bubble", 32'(bubz), 32'd0);
    chk("zero_dis_bubble", 32'(bub1), 32'd1);

    // Reset asserted mid-STALL with the detect condition still present.
    reset_all();
    load_use_inputs();
    edge1();
    #2 rst = 1;
    #1;
    chk("rst_mid_stall", 32'(stall3), 32'd0);
    chk("rst_mid_bubble", 32'(bub3), 32'd1);
    chk("rst_mid_fwd", 32'(fwd3), 32'd0);
    edge1();
    rst = 0;
    ex_valid = 0; ex_is_load = 0;
    #2 chk("rst_release_idle_stall", 32'(stall3), 32'd0);
    edge1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline forwarding logic. It computes operand-forward selects in ID, one cycle ahead, and registers them into EX so the EX operand muxes see a flop output rather than a comparator chain.
- It adds a load-use interlock with a configurable bubble count, a WB hold-register forward path, pipeline freeze and flush.
- It sits between the ID/EX pipeline register control and the EX operand muxes.

Parameters:
- REG_W, 3, register address width.
- NUM_SRC, 2, number of source operands per instruction.
- LOAD_STALL, 1, bubbles inserted on load-use; legal range 1..3.
- ZERO_REG_EN, 0, when 1 register 0 is never forwarded or stalled on.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_W  ID source addresses; operand i is at bits [i*REG_W +: REG_W].
- id_src_used  in  NUM_SRC  per-operand "reads register" flag.
- ex_valid, ex_is_load  in  1 each  EX writes a register / EX writer is a load.
- ex_rdst  in  REG_W  EX destination.
- me_valid  in  1  ME writes a register.
- me_rdst  in  REG_W  ME destination.
- wb_valid  in  1  WB writes a register.
- wb_rdst  in  REG_W  WB destination.
- ext_stall  in  1  freeze from other sources (e.g. memory wait).
- flush  in  1  kill ID/EX contents (branch taken).
- stall  out  1  combinational; hold PC and IF/ID.
- ex_bubble  out  1  registered; EX holds a bubble.
- fwd_ex  out  2*NUM_SRC  registered; per-operand forward select for EX.

Behaviour:
- Forward codes:
  - NOF=00: register file.
  - MEF=01: ME result.
  - WBF=10: WB result.
  - HLF=11: WB hold register, i.e. the value WB wrote one cycle earlier.
- Per operand i, match is defined as: id_src_used[i] and address equal. If ZERO_REG_EN=1, address 0 never matches.
- Priority, youngest first:
  - EX match -> MEF.
  - else ME match -> WBF.
  - else WB match -> HLF.
  - else NOF.
- Load-use detect: state IDLE, id_valid, ex_valid, ex_is_load, and any operand matches ex_rdst.
- stall = (detect or state==STALL) and not flush. stall is 0 while rst=1.
- advance = not ext_stall. All registers update only when advance or flush.
- Register update priority is flush > ext_stall > normal.
- Normal update:
  - If stall or not id_valid: ex_bubble<=1, fwd_ex<=0.
  - Otherwise: ex_bubble<=0, fwd_ex<=computed selects.
- Flush update: ex_bubble<=1, fwd_ex<=0, state<=IDLE, cnt<=0.
- FSM transitions (taken only on advance):
  - IDLE: on detect with LOAD_STALL>1, go to STALL and set cnt<=LOAD_STALL-2. With LOAD_STALL=1, stay in IDLE; detect self-clears because the load moves to ME.
  - STALL: if cnt==0, go to IDLE; else cnt<=cnt-1. Detect is ignored while in STALL.
- Total bubbles per load-use = LOAD_STALL. After release, the normal comparisons produce the select:
  - LOAD_STALL=1 -> WBF.
  - LOAD_STALL=2 -> HLF.
  - LOAD_STALL=3 -> NOF.
- Under ext_stall, stall stays asserted if already asserted, and cnt is frozen.
- cnt width: 2 bits.
- Reset values (async on rst rising, held while rst=1): fwd_ex=0, ex_bubble=1, state=IDLE, cnt=0.
- Latency: selects are computed in ID and visible on fwd_ex one clock later.

Decomposition:
- Shared package (pipeline_pkg): forward codes NOF/MEF/WBF/HLF, FSM state encoding IDLE/STALL, and REG_W default.
- One sub-module, fwd_select: a combinational per-operand priority comparator, instantiated NUM_SRC times via generate.
- FSM, counter and output registers live in the top module.

Test Plan:
- Reset: assert rst mid-STALL -> fwd_ex=0, ex_bubble=1, stall=0 immediately; after release, state IDLE.
- Priority: src0=5 used; ex/me/wb all valid with rdst=5 non-load -> next fwd_ex[1:0]=01. Drop ex_valid -> 10. Wb only -> 11. None -> 00. src1 unused with rdst=5 -> fwd_ex[3:2]=00.
- Load-use LOAD_STALL=1: ex load rdst=2, src1=2 -> stall=1 that cycle, next ex_bubble=1. Following cycle stall=0 -> next fwd_ex[3:2]=10, ex_bubble=0.
- LOAD_STALL=2 with ext_stall on the second bubble cycle -> stall high for 3 clocks total, cnt frozen during freeze. After release, op matching wb_rdst=2 -> fwd_ex=11.
- Flush in STALL (LOAD_STALL=3) -> stall=0 the same cycle, next ex_bubble=1, fwd_ex=0, state IDLE.
- ZERO_REG_EN=1: ex load rdst=0, src0=0 -> stall=0, fwd_ex[1:0]=00. ZERO_REG_EN=0, same stimulus -> stall=1.
